// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
package pc_pkg;

    // Event selected for the current edge, resolved by priority in the top.
    typedef enum logic [2:0] {
        EV_HOLD,
        EV_INC,
        EV_BRANCH,
        EV_JUMP,
        EV_CALL,
        EV_RET,
        EV_CONFLICT
    } pc_event_e;

    // Default PC value after reset and after a return with an empty stack.
    localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry and keeps the count saturated at DEPTH.
module pc_ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;   // slot the next push writes; top is wr_ptr-1
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty && !push;
    assign top_data = mem[wr_ptr - PW'(1)];

    // Storage is not reset; contents are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy; a full push wraps onto the oldest slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (do_pop) begin
            wr_ptr <= wr_ptr - PW'(1);
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with branch, jump, call/return via a
// hardware return-address stack, stall, and sticky error flags.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     STEP      = 1,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       stall,
    input  logic                       inc,
    input  logic                       jump,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       branch,
    input  logic [WIDTH-1:0]           target,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           pc_out,
    output logic [$clog2(DEPTH+1)-1:0] ras_count,
    output logic                       ras_full,
    output logic                       ras_empty,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       conflict
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    pc_event_e        ev;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] top_data;
    logic             push;
    logic             pop;
    logic             set_ov;
    logic             set_un;
    logic             set_cf;

    assign pc_seq = pc_out + STEP_V;

    // Priority encoder; a stalled cycle resolves to HOLD so nothing moves.
    always_comb begin
        ev = EV_HOLD;
        if (stall) begin
            ev = EV_HOLD;
        end else if ($countones({jump, call, ret, branch}) > 1) begin
            ev = EV_CONFLICT;
        end else if (ret) begin
            ev = EV_RET;
        end else if (call) begin
            ev = EV_CALL;
        end else if (jump) begin
            ev = EV_JUMP;
        end else if (branch) begin
            ev = EV_BRANCH;
        end else if (inc) begin
            ev = EV_INC;
        end
    end

    // Next-PC mux and stack/flag side effects of the selected event.
    always_comb begin
        pc_next = pc_out;
        push    = 1'b0;
        pop     = 1'b0;
        set_ov  = 1'b0;
        set_un  = 1'b0;
        set_cf  = 1'b0;
        case (ev)
            EV_CONFLICT: begin
                pc_next = pc_seq;
                set_cf  = 1'b1;
            end
            EV_RET: begin
                if (ras_empty) begin
                    pc_next = RESET_VEC;
                    set_un  = 1'b1;
                end else begin
                    pc_next = top_data;
                    pop     = 1'b1;
                end
            end
            EV_CALL: begin
                pc_next = target;
                push    = 1'b1;
                set_ov  = ras_full;
            end
            EV_JUMP:   pc_next = target;
            EV_BRANCH: pc_next = pc_out + offset;
            EV_INC:    pc_next = pc_seq;
            default:   pc_next = pc_out;
        endcase
    end

    pc_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .top_data  (top_data),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // PC register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out <= RESET_VEC;
        end else begin
            pc_out <= pc_next;
        end
    end

    // Sticky flags; a set in the same cycle as clr_err takes precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else if (!stall) begin
            overflow  <= set_ov | (overflow  & ~clr_err);
            underflow <= set_un | (underflow & ~clr_err);
            conflict  <= set_cf | (conflict  & ~clr_err);
        end
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: a queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pc_ras_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned ST = 4;
    localparam int unsigned D  = 4;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0, inc = 1'b0, jump = 1'b0, call = 1'b0;
    logic        ret = 1'b0, branch = 1'b0, clr_err = 1'b0;
    logic [31:0] target = '0, offset = '0;
    logic [31:0] pc_out;
    logic [2:0]  ras_count;
    logic        ras_full, ras_empty, overflow, underflow, conflict;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_ov, m_un, m_cf;
    bit          model_valid = 1'b0;

    pc_ras_unit #(
        .WIDTH     (W),
        .STEP      (ST),
        .DEPTH     (D),
        .RESET_VEC (RV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .inc       (inc),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .branch    (branch),
        .target    (target),
        .offset    (offset),
        .clr_err   (clr_err),
        .pc_out    (pc_out),
        .ras_count (ras_count),
        .ras_full  (ras_full),
        .ras_empty (ras_empty),
        .overflow  (overflow),
        .underflow (underflow),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = RV;
        m_q.delete();
        m_ov = 0;
        m_un = 0;
        m_cf = 0;
    endfunction

    // Apply the architectural rules to the inputs seen at the last edge.
    function automatic void model_step();
        int  n;
        bit  s_ov, s_un, s_cf;
        if (stall) return;
        n = int'(jump) + int'(call) + int'(ret) + int'(branch);
        s_ov = 0; s_un = 0; s_cf = 0;
        if (n > 1) begin
            m_pc = m_pc + ST;
            s_cf = 1;
        end else if (ret) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin
                m_pc = RV;
                s_un = 1;
            end
        end else if (call) begin
            if (m_q.size() == D) begin
                void'(m_q.pop_front());
                s_ov = 1;
            end
            m_q.push_back(m_pc + ST);
            m_pc = target;
        end else if (jump) begin
            m_pc = target;
        end else if (branch) begin
            m_pc = m_pc + offset;
        end else if (inc) begin
            m_pc = m_pc + ST;
        end
        if (clr_err) begin
            m_ov = 0; m_un = 0; m_cf = 0;
        end
        m_ov = m_ov | s_ov;
        m_un = m_un | s_un;
        m_cf = m_cf | s_cf;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("pc_out",    pc_out,                 m_pc);
            check("ras_count", {29'b0, ras_count},     m_q.size());
            check("ras_full",  {31'b0, ras_full},      {31'b0, m_q.size() == D});
            check("ras_empty", {31'b0, ras_empty},     {31'b0, m_q.size() == 0});
            check("overflow",  {31'b0, overflow},      {31'b0, m_ov});
            check("underflow", {31'b0, underflow},     {31'b0, m_un});
            check("conflict",  {31'b0, conflict},      {31'b0, m_cf});
        end
    end

    // One clocked event: drive after a falling edge, advance model after the rising edge.
    task automatic step(input bit s, input bit i, input bit j, input bit c,
                        input bit r, input bit b, input bit cl,
                        input logic [31:0] t, input logic [31:0] o);
        @(negedge clk);
        #1;
        stall = s; inc = i; jump = j; call = c; ret = r; branch = b;
        clr_err = cl; target = t; offset = o;
        @(posedge clk);
        #1;
        model_step();
        stall = 0; inc = 0; jump = 0; call = 0; ret = 0; branch = 0; clr_err = 0;
    endtask

    task automatic do_inc();                       step(0,1,0,0,0,0,0,'0,'0); endtask
    task automatic do_jump(input logic [31:0] t);  step(0,0,1,0,0,0,0,t,'0);  endtask
    task automatic do_call(input logic [31:0] t);  step(0,0,0,1,0,0,0,t,'0);  endtask
    task automatic do_ret();                       step(0,0,0,0,1,0,0,'0,'0); endtask
    task automatic do_br(input logic [31:0] o);    step(0,0,0,0,0,1,0,'0,o);  endtask

    initial begin
        model_reset();
        model_valid = 1'b1;
        #12;
        check("reset_pc",    pc_out, 32'h100);
        check("reset_empty", {31'b0, ras_empty}, 32'd1);
        check("reset_count", {29'b0, ras_count}, 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Reset then inc
        do_inc(); check("inc1", pc_out, 32'h104);
        do_inc(); check("inc2", pc_out, 32'h108);
        do_inc(); check("inc3", pc_out, 32'h10C);
        check("inc_empty", {31'b0, ras_empty}, 32'd1);

        // Hold with no event
        step(0,0,0,0,0,0,0,'0,'0); check("hold", pc_out, 32'h10C);

        // Branch wrap and positive branch
        do_jump(32'h108);
        do_br(32'hFFFF_FFF8); check("branch_neg", pc_out, 32'h100);
        do_br(32'h0000_0020); check("branch_pos", pc_out, 32'h120);
        do_jump(32'hFFFF_FFFC);
        do_inc(); check("inc_wrap", pc_out, 32'h0);

        // Call/ret nesting, ret right behind a call
        do_jump(32'h200);
        do_call(32'h400); check("call1", pc_out, 32'h400); check("cnt1", {29'b0, ras_count}, 32'd1);
        do_call(32'h500); check("call2", pc_out, 32'h500); check("cnt2", {29'b0, ras_count}, 32'd2);
        do_ret();         check("ret1",  pc_out, 32'h404); check("cnt3", {29'b0, ras_count}, 32'd1);
        do_ret();         check("ret2",  pc_out, 32'h204); check("cnt4", {29'b0, ras_count}, 32'd0);

        // Overflow then drain then underflow
        do_jump(32'h10);
        for (int k = 0; k < 5; k++) do_call(32'h10);
        check("ovf_flag",  {31'b0, overflow},   32'd1);
        check("ovf_count", {29'b0, ras_count},  32'd4);
        check("ovf_full",  {31'b0, ras_full},   32'd1);
        for (int k = 0; k < 4; k++) begin
            do_ret();
            check("drain_pc", pc_out, 32'h14);
        end
        do_ret();
        check("unf_pc",   pc_out, 32'h100);
        check("unf_flag", {31'b0, underflow}, 32'd1);
        step(0,0,0,0,0,0,1,'0,'0);
        check("clr_ovf", {31'b0, overflow},  32'd0);
        check("clr_unf", {31'b0, underflow}, 32'd0);

        // Stall drops a call
        step(1,0,0,1,0,0,0,32'h999,'0);
        check("stall_pc",  pc_out, 32'h100);
        check("stall_cnt", {29'b0, ras_count}, 32'd0);

        // Conflict, clear ignored under stall, set beats clear
        do_jump(32'h300);
        step(0,0,1,0,0,1,0,32'h800,32'h40);
        check("conf_pc",   pc_out, 32'h304);
        check("conf_flag", {31'b0, conflict}, 32'd1);
        step(1,0,0,0,0,0,1,'0,'0);
        check("stall_clr", {31'b0, conflict}, 32'd1);
        step(0,0,0,1,1,0,1,32'h900,'0);
        check("set_wins_pc",   pc_out, 32'h308);
        check("set_wins_flag", {31'b0, conflict}, 32'd1);
        check("conf_ras", {29'b0, ras_count}, 32'd0);

        // Async reset after two pushes
        do_call(32'h600);
        do_call(32'h700);
        check("pre_rst_cnt", {29'b0, ras_count}, 32'd2);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_pc",  pc_out, 32'h100);
        check("async_cnt", {29'b0, ras_count}, 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        do_ret();
        check("post_rst_ret", pc_out, 32'h100);
        check("post_rst_unf", {31'b0, underflow}, 32'd1);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
